// File: rtl/sys_bus_arbiter_pkg.sv
// ============================================================================
// sys_bus_arbiter_pkg : master IDs and encodings shared by the bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package sys_bus_arbiter_pkg;

    localparam logic       M0          = 1'b0;
    localparam logic       M1          = 1'b1;
    localparam logic [3:0] BYTEEN_READ = 4'b0000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sys_bus_arbiter_arb_rr2.sv
// ============================================================================
// arb_rr2 : two-way round-robin / M0-priority picker with last-grant register
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_rr2
    import sys_bus_arbiter_pkg::*;
#(
    parameter int CPU_PRIO = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic       force_m1_i,
    output logic [1:0] gnt_o
);

    logic       last_q;
    logic       last_d;
    logic [1:0] gnt;

    always_comb begin
        gnt = 2'b00;
        if (force_m1_i) begin
            gnt = 2'b10;
        end else begin
            case (req_i)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ((CPU_PRIO != 0) || (last_q == M1)) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // No grant may escape while reset is held low.
    assign gnt_o  = gnt & {2{rst_ni}};
    assign last_d = gnt_o[1] ? M1 : (gnt_o[0] ? M0 : last_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sys_bus_arbiter.sv
// ============================================================================
// sys_bus_arbiter : shares the bridge master port between CPU (M0) and DMA (M1)
// Rev 1.0
// ============================================================================
`default_nettype none

module sys_bus_arbiter
    import sys_bus_arbiter_pkg::*;
#(
    parameter int CPU_PRIO = 1,
    parameter int MAX_WAIT = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [3:0]  m0_byteen_i,
    output logic        m0_gnt_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_rvalid_o,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic [3:0]  m1_byteen_i,
    input  logic        m1_lock_i,
    output logic        m1_gnt_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_rvalid_o,
    output logic [31:0] br_addr_o,
    output logic [31:0] br_wdata_o,
    output logic [3:0]  br_byteen_o,
    input  logic [31:0] br_rd_i
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);
    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);

    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        locked_q,   locked_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        m0_rvalid_q, m0_rvalid_d;
    logic        m1_rvalid_q, m1_rvalid_d;

    logic [1:0]  gnt;
    logic        force_m1;
    logic [7:0]  lock_cnt_inc;

    // Lock hold and starvation guarantee both bypass the normal pick.
    assign force_m1 = m1_req_i & ((locked_q & (lock_cnt_q < MAX_LOCK_C)) |
                                  (wait_cnt_q >= MAX_WAIT_C));

    arb_rr2 #(
        .CPU_PRIO (CPU_PRIO)
    ) u_pick (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      ({m1_req_i, m0_req_i}),
        .force_m1_i (force_m1),
        .gnt_o      (gnt)
    );

    assign m0_gnt_o     = gnt[0];
    assign m1_gnt_o     = gnt[1];
    assign lock_cnt_inc = lock_cnt_q + 8'd1;

    always_comb begin
        br_addr_o   = 32'd0;
        br_wdata_o  = 32'd0;
        br_byteen_o = 4'd0;
        if (gnt[0]) begin
            br_addr_o   = m0_addr_i;
            br_wdata_o  = m0_wdata_i;
            br_byteen_o = m0_byteen_i;
        end else if (gnt[1]) begin
            br_addr_o   = m1_addr_i;
            br_wdata_o  = m1_wdata_i;
            br_byteen_o = m1_byteen_i;
        end
    end

    always_comb begin
        m0_rvalid_d = gnt[0] & (m0_byteen_i == BYTEEN_READ);
        m1_rvalid_d = gnt[1] & (m1_byteen_i == BYTEEN_READ);
        m0_rdata_d  = m0_rvalid_d ? br_rd_i : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? br_rd_i : m1_rdata_q;

        wait_cnt_d = (gnt[1] || !m1_req_i) ? 8'd0 : sat_inc8(wait_cnt_q);

        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        if (gnt[1]) begin
            // The lock budget includes the grant that acquires the lock.
            if (m1_lock_i && (lock_cnt_inc < MAX_LOCK_C)) begin
                locked_d   = 1'b1;
                lock_cnt_d = lock_cnt_inc;
            end else begin
                locked_d   = 1'b0;
                lock_cnt_d = 8'd0;
            end
        end else if (!m1_req_i && locked_q) begin
            locked_d   = 1'b0;
            lock_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q  <= 8'd0;
            lock_cnt_q  <= 8'd0;
            locked_q    <= 1'b0;
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
        end
    end

    assign m0_rdata_o  = m0_rdata_q;
    assign m1_rdata_o  = m1_rdata_q;
    assign m0_rvalid_o = m0_rvalid_q;
    assign m1_rvalid_o = m1_rvalid_q;

endmodule

`default_nettype wire
